// File: rtl/or_multi_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// or_multi_mon : two-sequence OR hit detector with hit counter and data merge.
// Optional assertions under OR_MULTI_MON_SVA_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module or_multi_mon (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk2,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic [31:0] data,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        w,
  output logic [31:0] x,
  output logic [31:0] y
);

  // clk2 exists only for pin compatibility with the original block.
  logic unused_clk2;
  assign unused_clk2 = clk2;

  logic        a_q1, b_q1, b_q2;
  logic        w_q, w_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        hit_a, hit_b, hit;

  assign hit_a = a_q1 & c;
  assign hit_b = b_q2 & d;
  assign hit   = hit_a | hit_b;

  always_comb begin
    w_d = e & hit;
    x_d = x_q;
    y_d = y_q;
    if (e && hit) begin
      x_d = x_q + 32'd1;
    end
    if (e) begin
      y_d = data | (a ? data1 : 32'd0) | (b ? data2 : 32'd0);
    end
  end

  // History runs independently of e so disabled-period requests still complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q1 <= 1'b0;
      b_q1 <= 1'b0;
      b_q2 <= 1'b0;
      w_q  <= 1'b0;
      x_q  <= 32'd0;
      y_q  <= 32'd0;
    end else begin
      a_q1 <= a;
      b_q1 <= b;
      b_q2 <= b_q1;
      w_q  <= w_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign w = w_q;
  assign x = x_q;
  assign y = y_q;

`ifdef OR_MULTI_MON_SVA_EN
  a_w_cause: assert property (@(posedge clk) disable iff (rst)
    w |-> $past(e) && ($past(a, 2) && $past(c) || $past(b, 3) && $past(d)));
  c_w_cause: cover property (@(posedge clk) disable iff (rst) w);

  a_x_step: assert property (@(posedge clk) disable iff (rst)
    (x != $past(x)) |-> (x == $past(x) + 32'd1) && w);
  c_x_step: cover property (@(posedge clk) disable iff (rst) x != $past(x));

  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({w, x, y}));
  c_no_x: cover property (@(posedge clk) disable iff (rst) y != 32'd0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_or_multi_mon.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_or_multi_mon : directed self-checking bench for or_multi_mon.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_or_multi_mon;

  logic        clk = 1'b0;
  logic        rst, clk2, a, b, c, d, e;
  logic [31:0] data, data1, data2;
  logic        w;
  logic [31:0] x, y;

  int n_pass  = 0;
  int n_total = 0;

  or_multi_mon dut (
    .clk  (clk),
    .rst  (rst),
    .clk2 (clk2),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .data (data),
    .data1(data1),
    .data2(data2),
    .w    (w),
    .x    (x),
    .y    (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle before inputs change or outputs are read.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ia, input logic ib, input logic ic,
                       input logic id, input logic ie);
    a = ia; b = ib; c = ic; d = id; e = ie;
  endtask

  initial begin
    clk2 = 1'b0;
    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    data = '1; data1 = '1; data2 = '1;
    step(); step();
    check("rst_w", {31'd0, w}, 32'd0);
    check("rst_x", x, 32'd0);
    check("rst_y", y, 32'd0);

    // First post-reset edge must not use pre-reset requests.
    rst = 1'b0;
    step();
    check("post_rst_w", {31'd0, w}, 32'd0);
    drive(0, 0, 0, 0, 1);
    data = '0; data1 = '0; data2 = '0;
    step(); step(); step();
    check("post_rst_x", x, 32'd0);

    // Sequence B only: hit two edges after b.
    drive(0, 1, 1, 1, 1);
    step();
    drive(0, 0, 1, 1, 1);
    step();
    check("seqB_early", {31'd0, w}, 32'd0);
    step();
    check("seqB_w", {31'd0, w}, 32'd1);
    step();
    check("seqB_end", {31'd0, w}, 32'd0);
    check("seqB_x", x, 32'd1);

    // Sequence A only: hit one edge after a.
    drive(1, 0, 1, 1, 1);
    step();
    check("seqA_early", {31'd0, w}, 32'd0);
    drive(0, 0, 1, 1, 1);
    step();
    check("seqA_w", {31'd0, w}, 32'd1);
    check("seqA_x", x, 32'd2);
    step();
    check("seqA_end", {31'd0, w}, 32'd0);

    // Coincident A and B completion: single increment.
    drive(0, 1, 1, 1, 1);
    step();
    drive(1, 0, 1, 1, 1);
    step();
    check("coin_early", {31'd0, w}, 32'd0);
    drive(0, 0, 1, 1, 1);
    step();
    check("coin_w", {31'd0, w}, 32'd1);
    check("coin_x", x, 32'd3);
    step();
    check("coin_end", {31'd0, w}, 32'd0);

    // Back-to-back a with c held: a pulse on every following edge.
    drive(1, 0, 1, 0, 1);
    step();
    step();
    check("b2b_w1", {31'd0, w}, 32'd1);
    step();
    check("b2b_w2", {31'd0, w}, 32'd1);
    drive(0, 0, 1, 0, 1);
    step();
    check("b2b_w3", {31'd0, w}, 32'd1);
    step();
    check("b2b_end", {31'd0, w}, 32'd0);
    check("b2b_x", x, 32'd6);

    // Sequence B started while disabled completes once e returns.
    drive(0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    check("dis_w", {31'd0, w}, 32'd0);
    drive(0, 0, 0, 1, 1);
    step();
    check("dis_late_w", {31'd0, w}, 32'd1);
    check("dis_late_x", x, 32'd7);

    // Hit while disabled is suppressed.
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 0, 0);
    step();
    check("gate_w", {31'd0, w}, 32'd0);
    check("gate_x", x, 32'd7);

    // Data merge and hold.
    data = 32'h0000_00F0; data1 = 32'h0000_000F; data2 = 32'hF000_0000;
    drive(1, 1, 0, 0, 1);
    step();
    check("merge_ab", y, 32'hF000_00FF);
    data = 32'h1234_5678; data1 = 32'h0F0F_0000; data2 = 32'h0000_0A00;
    drive(0, 0, 0, 0, 0);
    step();
    check("merge_hold", y, 32'hF000_00FF);
    data = 32'h0000_0001; data1 = 32'hFFFF_0000; data2 = 32'h0000_0100;
    drive(0, 1, 0, 0, 1);
    step();
    check("merge_b", y, 32'h0000_0101);
    drive(0, 0, 0, 0, 1);
    data = '0; data1 = '0; data2 = '0;
    step(); step();
    check("merge_x", x, 32'd7);

    // Counter wrap: preload to all-ones, then one hit.
    drive(0, 0, 0, 0, 0);
    force dut.x_q = 32'hFFFF_FFFF;
    #1;
    release dut.x_q;
    drive(1, 0, 1, 0, 1);
    step();
    drive(0, 0, 1, 0, 1);
    step();
    check("wrap_w", {31'd0, w}, 32'd1);
    check("wrap_x", x, 32'd0);

    // Reset one cycle after b discards the in-flight sequence.
    data = 32'hA5A5_A5A5;
    drive(0, 1, 0, 1, 1);
    step();
    drive(0, 0, 0, 1, 1);
    rst = 1'b1;
    step();
    check("mid_rst_y", y, 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_w0", {31'd0, w}, 32'd0);
    step();
    check("mid_rst_w1", {31'd0, w}, 32'd0);
    check("mid_rst_x", x, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
